mp_add_sequencer: RTL and testbench
===================================

MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

Interface
REQ-001 SHALL have parameter WORDS, default 4: number of 32-bit limbs, legal 2..8; operand width N = 32*WORDS.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port In_valid, input, 1: operand set offered.
REQ-005 SHALL have port In_ready, output, 1: block can accept operands.
REQ-006 SHALL have port A, input, N: first operand, limb 0 = bits [31:0].
REQ-007 SHALL have port B, input, N: second operand.
REQ-008 SHALL have port Cin, input, 1: carry into limb 0.
REQ-009 SHALL have port Out_valid, output, 1: result present.
REQ-010 SHALL have port Out_ready, input, 1: consumer takes result.
REQ-011 SHALL have port Sum, output, N: registered result, A+B+Cin mod 2^N.
REQ-012 SHALL have port Cout, output, 1: carry out of limb WORDS-1.

Function
REQ-013 SHALL implement FSM states IDLE, ADD, DONE.
REQ-014 SHALL drive In_ready = 1 only in IDLE and rst low; 0 in ADD and DONE.
REQ-015 SHALL, in IDLE on In_valid && In_ready edge, capture A, B, Cin into internal registers, clear limb index to 0, go to ADD.
REQ-016 SHALL, in each ADD cycle, add captured limb i of A and B plus carry register through one 32-bit adder slice, write the 32-bit result into Sum limb i, update carry register with the slice carry out, increment i.
REQ-017 SHALL use carry register = captured Cin for limb 0; no other carry source.
REQ-018 SHALL, on the edge that writes limb WORDS-1, load Cout with the final carry, assert Out_valid, go to DONE.
REQ-019 SHALL give latency: acceptance at edge 0 -> Out_valid high after edge WORDS.
REQ-020 SHALL, in DONE, hold Sum, Cout, Out_valid stable until Out_ready is high on an edge; on that edge clear Out_valid and go to IDLE.
REQ-021 SHALL ignore In_valid outside IDLE; captured operands unaffected by input changes after acceptance.
REQ-022 SHALL keep Sum limbs not yet written in ADD at their previous values; Sum is only valid while Out_valid is 1.
REQ-023 SHALL wrap sum modulo 2^N; overflow reported only via Cout (and Ovf, REQ-027).

Reset
REQ-024 SHALL, while rst is high, asynchronously force state IDLE, Out_valid 0, Sum 0, Cout 0, limb index 0, carry register 0, In_ready 0.
REQ-025 SHALL, on rst asserted mid-ADD or mid-DONE, discard the operation with no result delivered; first edge after rst release behaves as IDLE.

Configuration
REQ-026 SHALL gate signed overflow detection with macro MP_ADD_OVF_EN.
REQ-027 SHALL, with MP_ADD_OVF_EN defined, add output port Ovf (1 bit), loaded with Cout together as (A[N-1]==B[N-1]) && (Sum[N-1]!=A[N-1]) for captured operands, reset to 0, stable in DONE.
REQ-028 SHALL, without MP_ADD_OVF_EN, have no Ovf port and no related logic; all other behaviour identical.

Verification (WORDS=4)
REQ-029 SHALL check A=all ones, B=1, Cin=0 -> Sum=0, Cout=1, Out_valid rises exactly 4 edges after acceptance.
REQ-030 SHALL check A=0x0000_FFFF_FFFF, B=1, Cin=0 -> Sum=0x0001_0000_0000, Cout=0 (carry crosses limb 0->1).
REQ-031 SHALL check A=B=all ones, Cin=1 -> Sum=all ones, Cout=1.
REQ-032 SHALL check Out_ready low 3 cycles in DONE with In_valid high and new A -> Sum/Cout unchanged, In_ready=0, no second capture; Out_ready high -> IDLE next edge.
REQ-033 SHALL check rst pulse after 2 ADD cycles -> Out_valid=0, Sum=0 immediately; next op 0x1234_5678+0x8765_4321, Cin=1 -> Sum=0x9999_999A, Cout=0.
REQ-034 SHALL check with MP_ADD_OVF_EN: A=0x7FFF...F, B=1, Cin=0 -> Ovf=1, Cout=0, Sum=0x8000...0.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder: A+B+Cin computed one 32-bit limb per clock through a single slice.
// Optional signed-overflow output Ovf is built when MP_ADD_OVF_EN is defined.
module mp_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic [32*WORDS-1:0]   A,
    input  logic [32*WORDS-1:0]   B,
    input  logic                  Cin,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [32*WORDS-1:0]   Sum,
    output logic                  Cout
`ifdef MP_ADD_OVF_EN
    ,
    output logic                  Ovf
`endif
);

    localparam int unsigned N     = 32 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             step;
    logic             last_limb;
    logic             release_result;

    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     sum_q;
    logic             cout_q;
    logic             out_valid_q;
    logic [31:0]      a_limb;
    logic [31:0]      b_limb;
    logic [32:0]      slice;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        step           = 1'b0;
        release_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (In_valid && In_ready) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (last_limb) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Out_ready) begin
                    release_result = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready must drop while reset is held, so it cannot wait for a clock edge
    assign In_ready  = (state_q == IDLE) && !rst;
    assign last_limb = (idx_q == LAST_IDX);

    // One shared 32-bit slice, fed by the limb selected by idx_q
    always_comb begin
        a_limb = a_q[32*32'(idx_q) +: 32];
        b_limb = b_q[32*32'(idx_q) +: 32];
        slice  = {1'b0, a_limb} + {1'b0, b_limb} + 33'(carry_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= A;
                b_q     <= B;
                carry_q <= Cin;
                idx_q   <= '0;
            end
            if (step) begin
                sum_q[32*32'(idx_q) +: 32] <= slice[31:0];
                carry_q                    <= slice[32];
                idx_q                      <= idx_q + IDX_W'(1);
                if (last_limb) begin
                    cout_q      <= slice[32];
                    out_valid_q <= 1'b1;
                end
            end
            if (release_result) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef MP_ADD_OVF_EN
    logic ovf_q;

    // Signed overflow: like-signed operands producing an opposite-signed result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (step && last_limb) begin
            ovf_q <= (a_q[N-1] == b_q[N-1]) && (slice[31] != a_q[N-1]);
        end
    end

    assign Ovf = ovf_q;
`endif

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Out_valid = out_valid_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer (WORDS=4): directed corner cases plus random
// operands against a wide-integer reference model.
module tb_mp_add_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = 32 * WORDS;

    logic         clk;
    logic         rst;
    logic         In_valid;
    logic         In_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         Out_valid;
    logic         Out_ready;
    logic [N-1:0] Sum;
    logic         Cout;
`ifdef MP_ADD_OVF_EN
    logic         Ovf;
`endif

    int checks;
    int failures;

    mp_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef MP_ADD_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width integer sum, carry is the bit above N
    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    endfunction

    // Reference: true signed sum out of N-bit two's-complement range
    function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic cin);
        logic signed [N+1:0] s;
        logic signed [N+1:0] max_v;
        logic signed [N+1:0] min_v;
        s     = $signed({{2{a[N-1]}}, a}) + $signed({{2{b[N-1]}}, b}) + $signed((N+2)'(cin));
        max_v = $signed({2'b00, 1'b0, {(N-1){1'b1}}});
        min_v = $signed({2'b11, 1'b1, {(N-1){1'b0}}});
        return (s > max_v) || (s < min_v);
    endfunction

    function automatic logic [N-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one operand set, scramble inputs after acceptance, wait for the result
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          output int lat);
        @(negedge clk);
        A = a; B = b; Cin = cin; In_valid = 1'b1;
        @(posedge clk);
        #1;
        In_valid = 1'b0;
        A = rand_word(); B = rand_word(); Cin = ~cin;
        lat = 0;
        while (!Out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input int wait_cycles);
        repeat (wait_cycles) @(negedge clk);
        @(negedge clk);
        Out_ready = 1'b1;
        @(posedge clk);
        #1;
        Out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin);
        int lat;
        logic [N:0] exp;
        exp = ref_add(a, b, cin);
        run_op(a, b, cin, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL %s latency: got %0d edges, need 4", name, lat);
        end
        checks++;
        if (Sum !== exp[N-1:0] || Cout !== exp[N]) begin
            failures++;
            $display("FAIL %s sum: got %h cout %b, need %h cout %b", name, Sum, Cout,
                     exp[N-1:0], exp[N]);
        end
`ifdef MP_ADD_OVF_EN
        checks++;
        if (Ovf !== ref_ovf(a, b, cin)) begin
            failures++;
            $display("FAIL %s ovf: got %b, need %b", name, Ovf, ref_ovf(a, b, cin));
        end
`endif
        consume(0);
    endtask

    task automatic test_reset();
        rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (In_ready !== 1'b0 || Out_valid !== 1'b0 || Sum !== '0 || Cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: in_ready %b out_valid %b sum %h cout %b, need 0 0 0 0",
                     In_ready, Out_valid, Sum, Cout);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (In_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, need 1", In_ready);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ones;
        logic [N-1:0] one;
        ones = '1;
        one  = N'(1);
        check_op("all_ones_plus_1", ones, one, 1'b0);
        check_op("carry_limb0_to_1", N'(64'h0000_0000_FFFF_FFFF), one, 1'b0);
        check_op("ones_ones_cin", ones, ones, 1'b1);
        check_op("zero_zero", '0, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            check_op("random", rand_word(), rand_word(), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0] exp;
        int stray;
        a = rand_word(); b = rand_word();
        exp = ref_add(a, b, 1'b0);
        run_op(a, b, 1'b0, lat);
        checks++;
        if (Out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_reach_done: out_valid %b, need 1", Out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            In_valid = 1'b1; A = rand_word(); B = rand_word(); Out_ready = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (Sum !== exp[N-1:0] || Cout !== exp[N] || In_ready !== 1'b0 || Out_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle%0d: sum %h cout %b rdy %b vld %b, need %h %b 0 1",
                         c, Sum, Cout, In_ready, Out_valid, exp[N-1:0], exp[N]);
            end
        end
        @(negedge clk);
        In_valid = 1'b0; Out_ready = 1'b1;
        @(posedge clk);
        #1;
        Out_ready = 1'b0;
        checks++;
        if (Out_valid !== 1'b0 || In_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: out_valid %b in_ready %b, need 0 1", Out_valid, In_ready);
        end
        stray = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (Out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL hold_no_second_capture: out_valid high %0d cycles, need 0", stray);
        end
    endtask

    task automatic test_reset_mid_add();
        int lat;
        int stray;
        @(negedge clk);
        A = rand_word() | N'(1); B = '1; Cin = 1'b1; In_valid = 1'b1;
        @(posedge clk);
        #1;
        In_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (Out_valid !== 1'b0 || Sum !== '0 || Cout !== 1'b0 || In_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear: vld %b sum %h cout %b rdy %b, need 0 0 0 0",
                     Out_valid, Sum, Cout, In_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (Out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL mid_reset_discard: out_valid high %0d cycles, need 0", stray);
        end
        run_op(N'(32'h1234_5678), N'(32'h8765_4321), 1'b1, lat);
        checks++;
        if (lat !== 4 || Sum !== N'(32'h9999_999A) || Cout !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_op: lat %0d sum %h cout %b, need 4 %h 0",
                     lat, Sum, Cout, N'(32'h9999_999A));
        end
        consume(1);
    endtask

    task automatic test_overflow();
        logic [N-1:0] max_pos;
        max_pos = {1'b0, {(N-1){1'b1}}};
        check_op("signed_max_plus_1", max_pos, N'(1), 1'b0);
        check_op("signed_min_plus_min", {1'b1, {(N-1){1'b0}}}, {1'b1, {(N-1){1'b0}}}, 1'b0);
        check_op("mixed_sign", max_pos, '1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid_add();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
